// File: rtl/path_selector_n.sv
// Pipelined minimum-metric path selector: binary compare tree with one register stage per level.
// Define PATH_SELECTOR_METRIC_OUT_EN to add out_metric carrying the winning metric.
module path_selector_n #(
  parameter int NUM_STATES = 4,
  parameter int METRIC_W = 4,
  parameter int PATH_W = 8,
  parameter int TAG_W = 3,
  localparam int L = $clog2(NUM_STATES),
  localparam int S = (L < 1) ? 1 : L
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_STATES*PATH_W-1:0]   paths_in,
  input  logic [NUM_STATES*METRIC_W-1:0] metrics_in,
  input  logic [TAG_W-1:0]               tag_in,
  input  logic                           valid_in,
  output logic                           ready_in,
  output logic [PATH_W-1:0]              out_path,
  output logic [S-1:0]                   out_state,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           out_valid,
  input  logic                           out_ready
`ifdef PATH_SELECTOR_METRIC_OUT_EN
  ,
  output logic [METRIC_W-1:0]            out_metric
`endif
);

  // Registered entries of levels 1..L, packed level after level; the last one is the output stage.
  localparam int NR = NUM_STATES - 1;
  // Compare sources of levels 0..L-1: the input states followed by registered entries.
  localparam int NC = 2*NUM_STATES - 2;

`ifdef PATH_SELECTOR_METRIC_OUT_EN
  localparam bit KEEP_FINAL_METRIC = 1'b1;
`else
  localparam bit KEEP_FINAL_METRIC = 1'b0;
`endif

  function automatic int cur_base(input int lvl);
    return 2*NUM_STATES - 2*(NUM_STATES >> lvl);
  endfunction

  function automatic int reg_base(input int lvl);
    return NUM_STATES - 2*(NUM_STATES >> lvl);
  endfunction

  logic [METRIC_W-1:0] q_met [NR];
  logic [PATH_W-1:0]   q_pth [NR];
  logic [S-1:0]        q_idx [NR];

  logic [METRIC_W-1:0] d_met [NR];
  logic [PATH_W-1:0]   d_pth [NR];
  logic [S-1:0]        d_idx [NR];

  logic [METRIC_W-1:0] cur_met [NC];
  logic [PATH_W-1:0]   cur_pth [NC];
  logic [S-1:0]        cur_idx [NC];

  logic [TAG_W-1:0]    tag_q [L];
  logic [L-1:0]        vld_q;
  logic [L-1:0]        src_vld;
  logic [L-1:0]        load;
  logic                advance;

  assign advance   = !vld_q[L-1] || out_ready;
  assign ready_in  = advance;
  assign src_vld   = L'({vld_q, valid_in});
  // Data only moves with a valid bundle, so bubbles leave stage contents and outputs untouched.
  assign load      = advance ? src_vld : '0;

  assign out_valid = vld_q[L-1];
  assign out_path  = q_pth[NR-1];
  assign out_state = q_idx[NR-1];
  assign out_tag   = tag_q[L-1];
`ifdef PATH_SELECTOR_METRIC_OUT_EN
  assign out_metric = q_met[NR-1];
`endif

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      cur_met[i] = '0;
      cur_pth[i] = '0;
      cur_idx[i] = '0;
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      cur_met[i] = metrics_in[i*METRIC_W +: METRIC_W];
      cur_pth[i] = paths_in[i*PATH_W +: PATH_W];
    end
    for (int k = 0; k < NR - 1; k++) begin
      cur_met[NUM_STATES + k] = q_met[k];
      cur_pth[NUM_STATES + k] = q_pth[k];
      cur_idx[NUM_STATES + k] = q_idx[k];
    end
  end

  // Pairwise compare; <= keeps the lower-indexed child on ties, and the index gains its top bit here.
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      d_met[k] = '0;
      d_pth[k] = '0;
      d_idx[k] = '0;
    end
    for (int lvl = 1; lvl <= L; lvl++) begin
      for (int j = 0; j < (NUM_STATES >> lvl); j++) begin
        if (cur_met[cur_base(lvl-1) + 2*j] <= cur_met[cur_base(lvl-1) + 2*j + 1]) begin
          d_met[reg_base(lvl) + j] = cur_met[cur_base(lvl-1) + 2*j];
          d_pth[reg_base(lvl) + j] = cur_pth[cur_base(lvl-1) + 2*j];
          d_idx[reg_base(lvl) + j] = cur_idx[cur_base(lvl-1) + 2*j];
        end else begin
          d_met[reg_base(lvl) + j] = cur_met[cur_base(lvl-1) + 2*j + 1];
          d_pth[reg_base(lvl) + j] = cur_pth[cur_base(lvl-1) + 2*j + 1];
          d_idx[reg_base(lvl) + j] = cur_idx[cur_base(lvl-1) + 2*j + 1] | (S'(1) << (lvl - 1));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= src_vld;
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_tag
    logic [TAG_W-1:0] tag_src;
    if (s == 0) begin : g_src_in
      assign tag_src = tag_in;
    end else begin : g_src_prev
      assign tag_src = tag_q[s-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_q[s] <= '0;
      end else if (load[s]) begin
        tag_q[s] <= tag_src;
      end
    end
  end

  for (genvar lv = 1; lv <= L; lv++) begin : g_level
    for (genvar j = 0; j < (NUM_STATES >> lv); j++) begin : g_entry
      localparam int K = reg_base(lv) + j;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_pth[K] <= '0;
          q_idx[K] <= '0;
        end else if (load[lv-1]) begin
          q_pth[K] <= d_pth[K];
          q_idx[K] <= d_idx[K];
        end
      end

      // The output stage only keeps a metric when it is exported.
      if (lv < L || KEEP_FINAL_METRIC) begin : g_metric
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            q_met[K] <= '0;
          end else if (load[lv-1]) begin
            q_met[K] <= d_met[K];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_path_selector_n.sv
// Directed self-checking bench for path_selector_n: N=4 main instance plus N=8 and N=2 corner instances.
module tb_path_selector_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [15:0]  met4;
  logic [31:0]  pth4;
  logic [2:0]   tag4;
  logic         valid4;
  logic         ready4;
  logic         out_ready4;
  logic [7:0]   out_path4;
  logic [1:0]   out_state4;
  logic [2:0]   out_tag4;
  logic         out_valid4;

  logic [47:0]  met8;
  logic [127:0] pth8;
  logic [2:0]   tag8;
  logic         valid8;
  logic         ready8;
  logic [15:0]  out_path8;
  logic [2:0]   out_state8;
  logic [2:0]   out_tag8;
  logic         out_valid8;

  logic [7:0]   met2;
  logic [15:0]  pth2;
  logic [2:0]   tag2;
  logic         valid2;
  logic         ready2;
  logic [7:0]   out_path2;
  logic [0:0]   out_state2;
  logic [2:0]   out_tag2;
  logic         out_valid2;

`ifdef PATH_SELECTOR_METRIC_OUT_EN
  logic [3:0]   out_metric4;
  logic [5:0]   out_metric8;
  logic [3:0]   out_metric2;
`endif

  path_selector_n #(.NUM_STATES(4), .METRIC_W(4), .PATH_W(8), .TAG_W(3)) dut4 (
    .clk(clk), .rst(rst), .paths_in(pth4), .metrics_in(met4), .tag_in(tag4),
    .valid_in(valid4), .ready_in(ready4), .out_path(out_path4), .out_state(out_state4),
    .out_tag(out_tag4), .out_valid(out_valid4), .out_ready(out_ready4)
`ifdef PATH_SELECTOR_METRIC_OUT_EN
    , .out_metric(out_metric4)
`endif
  );

  path_selector_n #(.NUM_STATES(8), .METRIC_W(6), .PATH_W(16), .TAG_W(3)) dut8 (
    .clk(clk), .rst(rst), .paths_in(pth8), .metrics_in(met8), .tag_in(tag8),
    .valid_in(valid8), .ready_in(ready8), .out_path(out_path8), .out_state(out_state8),
    .out_tag(out_tag8), .out_valid(out_valid8), .out_ready(1'b1)
`ifdef PATH_SELECTOR_METRIC_OUT_EN
    , .out_metric(out_metric8)
`endif
  );

  path_selector_n #(.NUM_STATES(2), .METRIC_W(4), .PATH_W(8), .TAG_W(3)) dut2 (
    .clk(clk), .rst(rst), .paths_in(pth2), .metrics_in(met2), .tag_in(tag2),
    .valid_in(valid2), .ready_in(ready2), .out_path(out_path2), .out_state(out_state2),
    .out_tag(out_tag2), .out_valid(out_valid2), .out_ready(1'b1)
`ifdef PATH_SELECTOR_METRIC_OUT_EN
    , .out_metric(out_metric2)
`endif
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] met, input logic [31:0] pth,
                                input logic [2:0] tg, input logic vld);
    met4   = met;
    pth4   = pth;
    tag4   = tg;
    valid4 = vld;
  endtask

  // Stream bundle n: state n%4 has the unique smallest metric, path byte = {n, state}.
  function automatic logic [15:0] stream_met(input int n);
    logic [15:0] m;
    m = '0;
    for (int s = 0; s < 4; s++) m[s*4 +: 4] = (s == n % 4) ? 4'd2 : 4'd9;
    return m;
  endfunction

  function automatic logic [31:0] stream_pth(input int n);
    logic [31:0] p;
    p = '0;
    for (int s = 0; s < 4; s++) p[s*8 +: 8] = 8'(n*16 + s);
    return p;
  endfunction

  initial begin
    int sent;
    int recv;
    logic [2:0] frozen_tag;
    logic [7:0] frozen_path;

    apply_stimulus(16'h0, 32'h0, 3'd0, 1'b0);
    out_ready4 = 1'b1;
    met8 = '0; pth8 = '0; tag8 = '0; valid8 = 1'b0;
    met2 = '0; pth2 = '0; tag2 = '0; valid2 = 1'b0;

    #1 rst = 1'b1;
    #1;
    check_output("rst_valid", 32'(out_valid4), 32'd0);
    check_output("rst_path",  32'(out_path4),  32'd0);
    check_output("rst_state", 32'(out_state4), 32'd0);
    check_output("rst_tag",   32'(out_tag4),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rst_ready", 32'(ready4), 32'd1);
    tick();

    // Basic selection and two-level latency
    apply_stimulus(16'h5739, 32'hA3A2A1A0, 3'd5, 1'b1);
    tick();
    apply_stimulus(16'h5739, 32'hA3A2A1A0, 3'd5, 1'b0);
    check_output("lat_early_valid", 32'(out_valid4), 32'd0);
    tick();
    check_output("basic_valid", 32'(out_valid4), 32'd1);
    check_output("basic_state", 32'(out_state4), 32'd1);
    check_output("basic_path",  32'(out_path4),  32'hA1);
    check_output("basic_tag",   32'(out_tag4),   32'd5);
`ifdef PATH_SELECTOR_METRIC_OUT_EN
    check_output("basic_metric", 32'(out_metric4), 32'd3);
`endif

    // Ties and back-to-back throughput
    apply_stimulus(16'h2244, 32'h13121110, 3'd1, 1'b1);
    tick();
    apply_stimulus(16'h6666, 32'h13121110, 3'd2, 1'b1);
    tick();
    check_output("tie_a_state", 32'(out_state4), 32'd2);
    check_output("tie_a_path",  32'(out_path4),  32'h12);
    check_output("tie_a_tag",   32'(out_tag4),   32'd1);
    apply_stimulus(16'h1888, 32'h13121110, 3'd3, 1'b1);
    tick();
    check_output("tie_b_valid", 32'(out_valid4), 32'd1);
    check_output("tie_b_state", 32'(out_state4), 32'd0);
    check_output("tie_b_path",  32'(out_path4),  32'h10);
    check_output("tie_b_tag",   32'(out_tag4),   32'd2);
    apply_stimulus(16'h5739, 32'hA3A2A1A0, 3'd6, 1'b0);
    tick();
    check_output("high_state", 32'(out_state4), 32'd3);
    check_output("high_path",  32'(out_path4),  32'h13);
    tick();
    check_output("bubble_valid", 32'(out_valid4), 32'd0);
    check_output("bubble_hold_state", 32'(out_state4), 32'd3);
    check_output("bubble_hold_path",  32'(out_path4),  32'h13);

    // Stream of six with a four-cycle downstream stall
    sent = 0;
    recv = 0;
    frozen_tag = '0;
    frozen_path = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready4 = !(c >= 3 && c < 7);
      if (sent < 6) apply_stimulus(stream_met(sent), stream_pth(sent), 3'(sent), 1'b1);
      else          apply_stimulus(16'hFFFF, 32'h0, 3'd0, 1'b0);
      #1;
      if (c == 3) begin
        frozen_tag  = out_tag4;
        frozen_path = out_path4;
      end
      if (c >= 3 && c < 7) check_output("stall_ready", 32'(ready4), 32'd0);
      if (c >= 4 && c < 7) begin
        check_output("stall_hold_tag",  32'(out_tag4),  32'(frozen_tag));
        check_output("stall_hold_path", 32'(out_path4), 32'(frozen_path));
      end
      if (out_valid4 && out_ready4) begin
        if (recv >= 6) begin
          check_output("stream_dup", 32'(recv), 32'd5);
        end else begin
          check_output("stream_state", 32'(out_state4), 32'(recv % 4));
          check_output("stream_path",  32'(out_path4),  32'(recv*16 + recv % 4));
          check_output("stream_tag",   32'(out_tag4),   32'(recv));
        end
        recv++;
      end
      if (ready4 && sent < 6) sent++;
      tick();
    end
    check_output("stream_count", 32'(recv), 32'd6);

    // Reset with two bundles in flight
    out_ready4 = 1'b0;
    apply_stimulus(16'h5739, 32'hA3A2A1A0, 3'd6, 1'b1);
    tick();
    apply_stimulus(16'h5739, 32'hA3A2A1A0, 3'd7, 1'b1);
    tick();
    check_output("pre_rst_valid", 32'(out_valid4), 32'd1);
    rst = 1'b1;
    #1;
    check_output("arst_valid", 32'(out_valid4), 32'd0);
    check_output("arst_path",  32'(out_path4),  32'd0);
    check_output("arst_state", 32'(out_state4), 32'd0);
    check_output("arst_tag",   32'(out_tag4),   32'd0);
    rst = 1'b0;
    out_ready4 = 1'b1;
    apply_stimulus(16'h5515, 32'hC3C2C1C0, 3'd2, 1'b1);
    #1;
    check_output("post_rst_ready", 32'(ready4), 32'd1);
    tick();
    apply_stimulus(16'h5515, 32'hC3C2C1C0, 3'd2, 1'b0);
    check_output("post_rst_early", 32'(out_valid4), 32'd0);
    tick();
    check_output("post_rst_valid", 32'(out_valid4), 32'd1);
    check_output("post_rst_tag",   32'(out_tag4),   32'd2);
    check_output("post_rst_path",  32'(out_path4),  32'hC1);
    tick();
    check_output("post_rst_no_ghost", 32'(out_valid4), 32'd0);

    // N=8 wide metrics: only state 7 is below the maximum
    for (int s = 0; s < 8; s++) begin
      met8[s*6 +: 6]   = (s == 7) ? 6'd62 : 6'd63;
      pth8[s*16 +: 16] = 16'(16'hB000 + s);
    end
    tag8 = 3'd4;
    valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    check_output("n8_lat1", 32'(out_valid8), 32'd0);
    tick();
    check_output("n8_lat2", 32'(out_valid8), 32'd0);
    tick();
    check_output("n8_valid", 32'(out_valid8), 32'd1);
    check_output("n8_state", 32'(out_state8), 32'd7);
    check_output("n8_path",  32'(out_path8),  32'hB007);
    check_output("n8_tag",   32'(out_tag8),   32'd4);
`ifdef PATH_SELECTOR_METRIC_OUT_EN
    check_output("n8_metric", 32'(out_metric8), 32'd62);
`endif

    // N=2 single level
    met2 = {4'd5, 4'd5};
    pth2 = {8'hD1, 8'hD0};
    tag2 = 3'd1;
    valid2 = 1'b1;
    tick();
    check_output("n2_valid", 32'(out_valid2), 32'd1);
    check_output("n2_tie_state", 32'(out_state2), 32'd0);
    check_output("n2_tie_path",  32'(out_path2),  32'hD0);
    met2 = {4'd2, 4'd7};
    tag2 = 3'd2;
    tick();
    check_output("n2_state", 32'(out_state2), 32'd1);
    check_output("n2_path",  32'(out_path2),  32'hD1);
    check_output("n2_tag",   32'(out_tag2),   32'd2);
    valid2 = 1'b0;
    tick();
    check_output("n2_bubble", 32'(out_valid2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/path_selector_n.md
PATH_SELECTOR_N -- requirements
Module: path_selector_n

Interface
REQ-001 Parameter NUM_STATES, default 4: trellis state count; power of two, 2..64.
REQ-002 Parameter METRIC_W, default 4: unsigned path-metric width in bits.
REQ-003 Parameter PATH_W, default 8: survivor-path register width in bits.
REQ-004 Parameter TAG_W, default 3: sideband tag width (write pointer / sequence number).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 paths_in  input  NUM_STATES*PATH_W  survivor path of state i at bits [i*PATH_W +: PATH_W].
REQ-008 metrics_in  input  NUM_STATES*METRIC_W  path metric of state i at bits [i*METRIC_W +: METRIC_W].
REQ-009 tag_in  input  TAG_W  sideband carried alongside the decision.
REQ-010 valid_in  input  1  input bundle valid.
REQ-011 ready_in  output  1  block accepts a bundle this cycle.
REQ-012 out_path  output  PATH_W  survivor path of the winning state.
REQ-013 out_state  output  S=clog2(NUM_STATES)  index of the winning state.
REQ-014 out_tag  output  TAG_W  tag_in of the bundle that produced this decision.
REQ-015 out_valid  output  1  decision valid; held until accepted.
REQ-016 out_ready  input  1  downstream accepts the decision.

Function
REQ-017 Block SHALL select the state with minimum metric via a binary compare tree of L=clog2(NUM_STATES) levels, with one register stage per level.
REQ-018 Tie rule: each pairwise compare uses <=, so the lower state index SHALL win on equal metrics at every level (global lowest index among minima).
REQ-019 Each stage SHALL carry metric (METRIC_W), path (PATH_W), index (grows 1 bit per level), tag and a valid bit; no arithmetic widening; metrics compared unsigned.
REQ-020 Handshake: bundle accepted when valid_in && ready_in; decision retired when out_valid && out_ready.
REQ-021 advance = !out_valid || out_ready; ready_in SHALL equal advance (combinational, no dependency on valid_in).
REQ-022 When advance=1 all stages SHALL shift one level; when advance=0 all stage contents, including outputs, SHALL hold unchanged.
REQ-023 Latency: a bundle accepted at edge k with no stall SHALL appear on outputs with out_valid=1 after edge k+L-1 (L registered levels, last level is the output register).
REQ-024 Throughput SHALL be one decision per cycle under continuous valid_in and out_ready=1.
REQ-025 Bubbles (valid_in=0 on an advancing cycle) SHALL propagate as invalid stages; out_valid=0 while a bubble is at the output.
REQ-026 Outputs while out_valid=0 SHALL hold their last values (no requirement to clear).
REQ-027 Simultaneous accept and retire in the same cycle SHALL both take effect with no data loss or duplication.
REQ-028 NUM_STATES=2 SHALL yield L=1: single compare registered straight to the outputs.

Reset
REQ-029 rst=1 SHALL immediately clear all stage valid bits, out_valid, out_path, out_state, out_tag to 0, independent of clk.
REQ-030 Bundles in flight at reset SHALL be discarded, never emitted; ready_in SHALL be 1 on the first cycle after reset deassertion.

Configuration
REQ-031 Macro PATH_SELECTOR_METRIC_OUT_EN: when defined, extra output out_metric [METRIC_W] SHALL carry the winning metric, pipelined and reset (to 0) identically to out_path.
REQ-032 Without PATH_SELECTOR_METRIC_OUT_EN the port and metric storage in the final stage SHALL be absent; all other behaviour identical.

Verification
REQ-033 N=4, metrics {s0..s3}={9,3,7,5}, paths {0xA0,0xA1,0xA2,0xA3}, tag 5, out_ready=1 -> after 2 edges out_valid=1, out_state=1, out_path=0xA1, out_tag=5.
REQ-034 N=4, metrics {4,4,2,2} -> out_state=2; metrics {6,6,6,6} -> out_state=0 (lowest-index tie rule).
REQ-035 Stream 6 bundles back-to-back with out_ready held 0 from cycle 3 for 4 cycles -> ready_in=0 during stall, outputs frozen, all 6 decisions emitted in order, none lost or duplicated.
REQ-036 Assert rst for one cycle mid-stream with 2 bundles in flight -> outputs 0 asynchronously, in-flight bundles never appear, next accepted bundle emerges after L cycles.
REQ-037 N=8, METRIC_W=6, PATH_W=16, metrics max value 63 on all but state 7 = 62 -> out_state=7 after 3 cycles; N=2 instance -> latency 1.
REQ-038 With PATH_SELECTOR_METRIC_OUT_EN defined, REQ-033 stimulus -> out_metric=3 aligned with out_valid.
